// File: rtl/maxpool_2x2.sv
// maxpool_2x2: 2x2 stride-2 max pooling of a row-major FP16 pixel stream.
// Even rows are reduced pairwise into a half-width line buffer. Odd rows are
// reduced pairwise as well and then combined with the buffered even-row pair,
// so one pooled pixel is emitted for every 2x2 window.
// Optional build macro: MAXPOOL_BYPASS_EN adds the pool_bypass input, which
// forwards every input pixel straight to the output with a latency of 1.
module maxpool_2x2 #(
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int MAX_ROW_WIDTH   = 416,
    parameter int COL_CNT_WIDTH   = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [COL_CNT_WIDTH-1:0]   row_width,
    input  logic                       frame_start,
`ifdef MAXPOOL_BYPASS_EN
    input  logic                       pool_bypass,
`endif
    input  logic [BRAM_DATA_WIDTH-1:0] pixel_data_in,
    input  logic                       pixel_data_valid_in,
    output logic [BRAM_DATA_WIDTH-1:0] pool_data_out,
    output logic                       pool_data_valid_out
);

    // One line-buffer entry per horizontal pixel pair of an even row.
    localparam int LINE_DEPTH = MAX_ROW_WIDTH / 2;
    localparam int ADDR_WIDTH = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
    localparam int SIGN_BIT   = BRAM_DATA_WIDTH - 1;

    // A/B name the first/second pixel of a horizontal pair, EVEN/ODD the row parity.
    typedef enum logic [1:0] {
        EVEN_A = 2'd0,
        EVEN_B = 2'd1,
        ODD_A  = 2'd2,
        ODD_B  = 2'd3
    } pool_state_t;

    pool_state_t                 state;
    pool_state_t                 next_state;
    pool_state_t                 eff_state;
    logic [COL_CNT_WIDTH-1:0]    col_cnt;
    logic [COL_CNT_WIDTH-1:0]    next_col;
    logic [COL_CNT_WIDTH-1:0]    eff_col;
    logic [COL_CNT_WIDTH-1:0]    last_col;
    logic                        end_row;
    logic                        armed;
    logic                        next_armed;
    logic                        bypass_on;
    logic                        accept;
    logic                        start;
    logic                        load_pair;
    logic                        lb_wr_en;
    logic                        lb_rd_en;
    logic                        emit;
    logic [ADDR_WIDTH-1:0]       lb_addr;
    logic [BRAM_DATA_WIDTH-1:0]  pair_r;
    logic [BRAM_DATA_WIDTH-1:0]  pair_max;
    logic [BRAM_DATA_WIDTH-1:0]  window_max;
    logic [BRAM_DATA_WIDTH-1:0]  lb_rd_data;
    logic [BRAM_DATA_WIDTH-1:0]  line_mem [LINE_DEPTH];

    // Half-precision maximum using only integer compares on the bit pattern.
    // A positive operand always wins over a negative one (so +0 beats -0);
    // with equal signs the larger magnitude wins for positives and the
    // smaller magnitude wins for negatives. NaN/Inf follow the same rule.
    function automatic logic [BRAM_DATA_WIDTH-1:0] fp16_max(
        input logic [BRAM_DATA_WIDTH-1:0] a,
        input logic [BRAM_DATA_WIDTH-1:0] b
    );
        logic [BRAM_DATA_WIDTH-1:0] res;
        if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            res = a[SIGN_BIT] ? b : a;
        end else if (!a[SIGN_BIT]) begin
            res = (a[SIGN_BIT-1:0] >= b[SIGN_BIT-1:0]) ? a : b;
        end else begin
            res = (a[SIGN_BIT-1:0] <= b[SIGN_BIT-1:0]) ? a : b;
        end
        return res;
    endfunction

`ifdef MAXPOOL_BYPASS_EN
    assign bypass_on = pool_bypass;
`else
    assign bypass_on = 1'b0;
`endif

    // A frame_start pixel restarts the window walk before it is consumed,
    // so the FSM works from these "effective" position values.
    assign accept    = pixel_data_valid_in && !bypass_on;
    assign start     = accept && frame_start;
    assign eff_state = start ? EVEN_A : state;
    assign eff_col   = start ? '0 : col_cnt;
    assign last_col  = row_width - COL_CNT_WIDTH'(1);
    assign end_row   = (eff_col == last_col);
    assign lb_addr   = eff_col[ADDR_WIDTH:1];

    // Horizontal pair maximum feeds the line buffer; the odd-row pair is
    // further combined with the buffered even-row pair to close the window.
    assign pair_max   = fp16_max(pair_r, pixel_data_in);
    assign window_max = fp16_max(lb_rd_data, pair_max);

    // Next-state and datapath control decode for each accepted pixel.
    always_comb begin
        next_state = state;
        next_col   = col_cnt;
        next_armed = armed || start;
        load_pair  = 1'b0;
        lb_wr_en   = 1'b0;
        lb_rd_en   = 1'b0;
        emit       = 1'b0;

        // Pixels arriving after reset but before any frame_start are ignored.
        if (accept && (armed || start)) begin
            next_col = end_row ? '0 : eff_col + COL_CNT_WIDTH'(1);
            case (eff_state)
                EVEN_A: begin
                    // A trailing pixel of an odd-width row is dropped here.
                    load_pair  = !end_row;
                    next_state = end_row ? ODD_A : EVEN_B;
                end
                EVEN_B: begin
                    lb_wr_en   = 1'b1;
                    next_state = end_row ? ODD_A : EVEN_A;
                end
                ODD_A: begin
                    // Issue the line-buffer read now so it is ready in ODD_B.
                    load_pair  = !end_row;
                    lb_rd_en   = !end_row;
                    next_state = end_row ? EVEN_A : ODD_B;
                end
                ODD_B: begin
                    emit       = 1'b1;
                    next_state = end_row ? EVEN_A : ODD_A;
                end
                default: begin
                    next_state = EVEN_A;
                end
            endcase
        end
    end

    // FSM state, column counter, frame-armed flag and pending pair register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EVEN_A;
            col_cnt <= '0;
            armed   <= 1'b0;
            pair_r  <= '0;
        end else begin
            state   <= next_state;
            col_cnt <= next_col;
            armed   <= next_armed;
            if (load_pair) begin
                pair_r <= pixel_data_in;
            end
        end
    end

    // Line buffer: synchronous write of even-row pairs, synchronous read for odd rows.
    always_ff @(posedge clk) begin
        if (lb_wr_en) begin
            line_mem[lb_addr] <= pair_max;
        end
        if (lb_rd_en) begin
            lb_rd_data <= line_mem[lb_addr];
        end
    end

    // Registered output: one-cycle valid pulse per pooled (or bypassed) pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_data_out       <= '0;
            pool_data_valid_out <= 1'b0;
        end else begin
            pool_data_valid_out <= 1'b0;
            if (bypass_on && pixel_data_valid_in) begin
                pool_data_out       <= pixel_data_in;
                pool_data_valid_out <= 1'b1;
            end else if (emit) begin
                pool_data_out       <= window_max;
                pool_data_valid_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2: randomized self-checking bench for maxpool_2x2.
// A positional reference model tracks (row, col) of every accepted pixel and
// predicts each pooled value plus the cycle it must appear on.
module tb_maxpool_2x2;

    logic        clk;
    logic        rst_n;
    logic [8:0]  row_width;
    logic        frame_start;
    logic [15:0] pixel_data_in;
    logic        pixel_data_valid_in;
    logic [15:0] pool_data_out;
    logic        pool_data_valid_out;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          total;
    int          bad;
    int          cyc;
    int          out_cnt;
    bit          mon_en;

    // Reference model state: frame position and the last two rows seen.
    bit          m_armed;
    int          m_row;
    int          m_col;
    logic [15:0] m_line [2][416];

    maxpool_2x2 dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .row_width           (row_width),
        .frame_start         (frame_start),
`ifdef MAXPOOL_BYPASS_EN
        .pool_bypass         (1'b0),
`endif
        .pixel_data_in       (pixel_data_in),
        .pixel_data_valid_in (pixel_data_valid_in),
        .pool_data_out       (pool_data_out),
        .pool_data_valid_out (pool_data_valid_out)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time-stamp expected outputs.
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    // Ordering key: every FP16 pattern maps to an integer so that "larger key"
    // means "larger value" under the bit-pattern rule, with -0 just below +0.
    function automatic int fkey(input logic [15:0] h);
        if (h[15]) return -int'(h[14:0]) - 1;
        return int'(h[14:0]);
    endfunction

    function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
        return (fkey(a) >= fkey(b)) ? a : b;
    endfunction

    // Drive one cycle of input and let the model predict any resulting output.
    task automatic applyStimulus(input logic fs, input logic [15:0] pix, input logic v);
        logic [15:0] w;
        @(posedge clk);
        #1;
        frame_start         = fs;
        pixel_data_in       = pix;
        pixel_data_valid_in = v;
        if (v) begin
            if (fs) begin
                m_armed = 1'b1;
                m_row   = 0;
                m_col   = 0;
            end
            if (m_armed) begin
                m_line[m_row % 2][m_col] = pix;
                if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                    w = fmax(fmax(m_line[0][m_col-1], m_line[0][m_col]),
                             fmax(m_line[1][m_col-1], pix));
                    exp_q.push_back('{cyc + 1, w});
                end
                m_col++;
                if (m_col == int'(row_width)) begin
                    m_col = 0;
                    m_row++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    endtask

    // Stream a whole frame of random pixels, optionally with random idle gaps.
    task automatic randomFrame(input int width, input int rows, input bit gaps);
        row_width = 9'(width);
        for (int i = 0; i < width * rows; i++) begin
            if (gaps && $urandom_range(1, 0) == 1) idle(1);
            applyStimulus(i == 0, 16'($urandom()), 1'b1);
        end
        idle(3);
    endtask

    task automatic sendWindow(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        row_width = 9'd2;
        applyStimulus(1'b1, a, 1'b1);
        applyStimulus(1'b0, b, 1'b1);
        applyStimulus(1'b0, c, 1'b1);
        applyStimulus(1'b0, d, 1'b1);
        idle(2);
    endtask

    // Output monitor: every cycle, valid must match the model's schedule.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_v;
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            checkOutput("valid", {15'b0, pool_data_valid_out}, {15'b0, exp_v});
            if (exp_v) begin
                checkOutput("data", pool_data_out, exp_q[0].val);
                void'(exp_q.pop_front());
            end
            if (pool_data_valid_out) out_cnt++;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [15:0] ramp [16];
        int          base;
        bit          seen;

        ramp = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600,
                 16'h4700, 16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00,
                 16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};
        total = 0; bad = 0; cyc = 0; out_cnt = 0; mon_en = 1'b0;
        m_armed = 1'b0; m_row = 0; m_col = 0;
        rst_n = 1'b0; frame_start = 1'b0; pixel_data_in = '0;
        pixel_data_valid_in = 1'b0; row_width = 9'd4;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_valid", {15'b0, pool_data_valid_out}, 16'h0000);
        checkOutput("reset_data", pool_data_out, 16'h0000);
        mon_en = 1'b1;

        // 4x4 ramp 1.0..16.0.
        row_width = 9'd4;
        base = out_cnt;
        for (int i = 0; i < 16; i++) applyStimulus(i == 0, ramp[i], 1'b1);
        idle(3);
        checkOutput("ramp_count", 16'(out_cnt - base), 16'd4);

        // Sign handling windows.
        sendWindow(16'hAE66, 16'hC000, 16'h8000, 16'h0000);
        sendWindow(16'hC000, 16'hBC00, 16'hC200, 16'hC400);
        sendWindow(16'h0000, 16'h8000, 16'hAE66, 16'h8000);
        sendWindow(16'h7C00, 16'h7E00, 16'hFC00, 16'h3C00);

        // Odd row width: last column dropped, then realign with a new frame.
        base = out_cnt;
        randomFrame(5, 2, 1'b0);
        checkOutput("odd_width_count", 16'(out_cnt - base), 16'd2);
        randomFrame(4, 4, 1'b0);

        // Full-width frame with ~50% valid gaps.
        base = out_cnt;
        randomFrame(416, 2, 1'b1);
        checkOutput("wide_count", 16'(out_cnt - base), 16'd208);

        // frame_start in the middle of row 1 aborts the partial window.
        row_width = 9'd4;
        for (int i = 0; i < 7; i++) applyStimulus(i == 0, 16'($urandom()), 1'b1);
        randomFrame(4, 2, 1'b0);

        // Mixed frames: random widths, row counts and gaps.
        for (int f = 0; f < 6; f++) begin
            randomFrame(int'($urandom_range(9, 2)), int'($urandom_range(4, 2)), 1'b1);
        end

        // Asynchronous reset while an output is valid.
        idle(2);
        mon_en = 1'b0;
        row_width = 9'd2;
        applyStimulus(1'b1, 16'($urandom()), 1'b1);
        applyStimulus(1'b0, 16'($urandom()), 1'b1);
        applyStimulus(1'b0, 16'($urandom()), 1'b1);
        applyStimulus(1'b0, 16'($urandom()), 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk);
            #1;
            pixel_data_valid_in = 1'b0;
            frame_start = 1'b0;
            seen = pool_data_valid_out;
        end
        checkOutput("pre_reset_valid", {15'b0, pool_data_valid_out}, 16'h0001);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", {15'b0, pool_data_valid_out}, 16'h0000);
        checkOutput("async_reset_data", pool_data_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_armed = 1'b0; m_row = 0; m_col = 0;
        mon_en = 1'b1;

        // Pixels without frame_start after reset produce nothing.
        base = out_cnt;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'($urandom()), 1'b1);
        idle(2);
        checkOutput("no_frame_count", 16'(out_cnt - base), 16'd0);
        randomFrame(2, 2, 1'b0);
        randomFrame(6, 3, 1'b1);

        idle(4);
        checkOutput("drain", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
